// File: rtl/rst_pkg.sv
// rtl/rst_pkg.sv - shared types and constants for the reset sequencer
// Purpose: sequencer state encoding and reset-cause bit positions.
// Ports: none (package).
package rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int CAUSE_W   = 4;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_BTN = 1;
  localparam int CAUSE_PLL = 2;
  localparam int CAUSE_SW  = 3;

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - reset cause inputs and sequenced reset outputs
// Purpose: bundles the reset-cause inputs and the per-domain reset outputs.
// Signals:
//   pll_locked  MMCM lock, asynchronous
//   btn         raw reset button, asynchronous, active-high
//   sw_rst_req  one-cycle software reset pulse, synchronous
//   rst_n_o     per-domain active-low resets
//   ready       all domains released
//   rst_cause   cause of the last reset {sw, pll, btn, por}
// Modports: master drives the causes, slave is the sequencer.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  import rst_pkg::*;

  logic                   pll_locked;
  logic                   btn;
  logic                   sw_rst_req;
  logic [NUM_DOMAINS-1:0] rst_n_o;
  logic                   ready;
  logic [CAUSE_W-1:0]     rst_cause;

  modport master (
    output pll_locked, btn, sw_rst_req,
    input  rst_n_o, ready, rst_cause
  );

  modport slave (
    input  pll_locked, btn, sw_rst_req,
    output rst_n_o, ready, rst_cause
  );

endinterface

// File: rtl/debounce.sv
// rtl/debounce.sv - level debouncer for an already synchronised input
// Purpose: output follows the input only after CYCLES consecutive
//          disagreeing cycles; any agreeing cycle restarts the count.
// Ports: clk, rst (async active-high), d (synchronised in), q (stable out).
module debounce #(
  parameter int CYCLES = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sync.sv
// rtl/sync.sv - multi-stage synchroniser for an asynchronous level
// Purpose: brings an asynchronous level into the clk domain.
// Ports: clk, rst (async active-high), d (async in), q (synchronised out).
module sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-domain ordered reset release with cause capture
// Purpose: merges lock loss, debounced button and software reset into one
//          condition, holds all domains in reset until it has been clear for
//          MIN_HOLD cycles, then releases domain 0 first and each further
//          domain STAGE_DELAY cycles later. Records the last reset cause.
// Ports:
//   clk   sequencer clock
//   rst   asynchronous active-high power-on reset
//   bus   reset_sequencer_if.slave (pll_locked, btn, sw_rst_req in;
//         rst_n_o, ready, rst_cause out, all registered)
module reset_sequencer
  import rst_pkg::*;
#(
  parameter int NUM_DOMAINS     = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int MIN_HOLD        = 16,
  parameter int STAGE_DELAY     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  reset_sequencer_if.slave     bus
);

  localparam int HOLD_W  = $clog2(MIN_HOLD + 1);
  localparam int STAGE_W = $clog2(STAGE_DELAY + 1);

  logic btn_s;
  logic btn_db;
  logic locked_s;

  sync #(.STAGES(SYNC_STAGES)) u_sync_pll (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  sync #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn),
    .q   (btn_s)
  );

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk (clk),
    .rst (rst),
    .d   (btn_s),
    .q   (btn_db)
  );

  logic [CAUSE_W-1:0] cause_vec;
  logic               cause_any;
  logic               ok;

  always_comb begin
    cause_vec            = '0;
    cause_vec[CAUSE_SW]  = bus.sw_rst_req;
    cause_vec[CAUSE_PLL] = ~locked_s;
    cause_vec[CAUSE_BTN] = btn_db;
  end

  assign cause_any = |cause_vec;
  assign ok        = locked_s & ~btn_db & ~bus.sw_rst_req;

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt, hold_d;
  logic [STAGE_W-1:0]     stage_cnt, stage_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;
  logic [CAUSE_W-1:0]     cause_q, cause_d;

  logic                   hold_done;
  logic                   stage_done;
  logic [NUM_DOMAINS-1:0] rst_n_shift;

  assign hold_done   = ok && (hold_cnt == HOLD_W'(MIN_HOLD - 1));
  assign stage_done  = (stage_cnt == STAGE_W'(STAGE_DELAY - 1));
  // Domains release as a thermometer code; all ones means the last one is out.
  assign rst_n_shift = (rst_n_q << 1) | NUM_DOMAINS'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD: begin
        if (hold_done) begin
          state_d = (NUM_DOMAINS == 1) ? RUN : RELEASE;
        end
      end
      RELEASE: begin
        if (cause_any) begin
          state_d = HOLD;
        end else if (stage_done && (&rst_n_shift)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cause_any) begin
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // Output and counter next values; registered below so outputs are glitch-free.
  always_comb begin
    hold_d  = hold_cnt;
    stage_d = stage_cnt;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    cause_d = cause_q;
    unique case (state_q)
      HOLD: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        stage_d = '0;
        if (!ok) begin
          hold_d = '0;
        end else if (hold_done) begin
          hold_d  = '0;
          rst_n_d = NUM_DOMAINS'(1);
          ready_d = (NUM_DOMAINS == 1);
        end else begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      RELEASE, RUN: begin
        if (cause_any) begin
          // Re-assert every domain together, including already released ones.
          rst_n_d = '0;
          ready_d = 1'b0;
          hold_d  = '0;
          stage_d = '0;
          cause_d = cause_vec;
        end else if (state_q == RELEASE) begin
          if (stage_done) begin
            rst_n_d = rst_n_shift;
            stage_d = '0;
            ready_d = &rst_n_shift;
          end else begin
            stage_d = stage_cnt + STAGE_W'(1);
          end
        end
      end
      default: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        hold_d  = '0;
        stage_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      stage_cnt <= '0;
      rst_n_q   <= '0;
      ready_q   <= 1'b0;
      cause_q   <= CAUSE_W'(1) << CAUSE_POR;
    end else begin
      hold_cnt  <= hold_d;
      stage_cnt <= stage_d;
      rst_n_q   <= rst_n_d;
      ready_q   <= ready_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.rst_n_o   = rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  reset_sequencer_if #(.NUM_DOMAINS(3)) bus ();

  reset_sequencer #(
    .NUM_DOMAINS     (3),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (5),
    .MIN_HOLD        (4),
    .STAGE_DELAY     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b1;
    bus.btn = 1'b0;
    bus.sw_rst_req = 1'b0;
    step(3);
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL reset_rst_n got=%b exp=000", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.rst_cause !== 4'b0001) begin errors++; $display("FAIL reset_cause got=%b exp=0001", bus.rst_cause); end
  endtask

  task automatic test_por_release();
    @(posedge clk); #1;
    rst = 1'b0;
    step(5);
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL por_e5 got=%b exp=000", bus.rst_n_o); end
    step(1);
    checks++; if (bus.rst_n_o !== 3'b001) begin errors++; $display("FAIL por_e6 got=%b exp=001", bus.rst_n_o); end
    step(2);
    checks++; if (bus.rst_n_o !== 3'b001) begin errors++; $display("FAIL por_e8 got=%b exp=001", bus.rst_n_o); end
    step(1);
    checks++; if (bus.rst_n_o !== 3'b011) begin errors++; $display("FAIL por_e9 got=%b exp=011", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL por_e9_ready got=%b exp=0", bus.ready); end
    step(2);
    checks++; if (bus.rst_n_o !== 3'b011) begin errors++; $display("FAIL por_e11 got=%b exp=011", bus.rst_n_o); end
    step(1);
    checks++; if (bus.rst_n_o !== 3'b111) begin errors++; $display("FAIL por_e12 got=%b exp=111", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL por_e12_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.rst_cause !== 4'b0001) begin errors++; $display("FAIL por_cause got=%b exp=0001", bus.rst_cause); end
  endtask

  task automatic test_button_press();
    bus.btn = 1'b1;
    step(7);
    checks++; if (bus.rst_n_o !== 3'b111) begin errors++; $display("FAIL btn_e7 got=%b exp=111", bus.rst_n_o); end
    step(1);
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL btn_e8 got=%b exp=000", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL btn_e8_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.rst_cause !== 4'b0010) begin errors++; $display("FAIL btn_cause got=%b exp=0010", bus.rst_cause); end
    step(12);
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL btn_held got=%b exp=000", bus.rst_n_o); end
    bus.btn = 1'b0;
    step(10);
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL btn_rel_e10 got=%b exp=000", bus.rst_n_o); end
    step(1);
    checks++; if (bus.rst_n_o !== 3'b001) begin errors++; $display("FAIL btn_rel_e11 got=%b exp=001", bus.rst_n_o); end
    step(6);
    checks++; if (bus.rst_n_o !== 3'b111) begin errors++; $display("FAIL btn_rel_e17 got=%b exp=111", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL btn_rel_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.rst_cause !== 4'b0010) begin errors++; $display("FAIL btn_rel_cause got=%b exp=0010", bus.rst_cause); end
  endtask

  task automatic test_button_glitch();
    bus.btn = 1'b1;
    step(4);
    bus.btn = 1'b0;
    step(4);
    checks++; if (bus.rst_n_o !== 3'b111) begin errors++; $display("FAIL glitch_mid got=%b exp=111", bus.rst_n_o); end
    step(6);
    checks++; if (bus.rst_n_o !== 3'b111) begin errors++; $display("FAIL glitch_end got=%b exp=111", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL glitch_ready got=%b exp=1", bus.ready); end
  endtask

  task automatic test_lock_loss();
    // Software pulse from RUN gives a clean restart to reach the 011 phase.
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL sw_run got=%b exp=000", bus.rst_n_o); end
    checks++; if (bus.rst_cause !== 4'b1000) begin errors++; $display("FAIL sw_cause got=%b exp=1000", bus.rst_cause); end
    step(4);
    checks++; if (bus.rst_n_o !== 3'b001) begin errors++; $display("FAIL sw_rel_e5 got=%b exp=001", bus.rst_n_o); end
    step(3);
    checks++; if (bus.rst_n_o !== 3'b011) begin errors++; $display("FAIL sw_rel_e8 got=%b exp=011", bus.rst_n_o); end
    bus.pll_locked = 1'b0;
    step(2);
    checks++; if (bus.rst_n_o !== 3'b011) begin errors++; $display("FAIL lock_e2 got=%b exp=011", bus.rst_n_o); end
    step(1);
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL lock_e3 got=%b exp=000", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL lock_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.rst_cause !== 4'b0100) begin errors++; $display("FAIL lock_cause got=%b exp=0100", bus.rst_cause); end
  endtask

  task automatic test_sw_in_hold();
    step(3);
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL nolock_hold got=%b exp=000", bus.rst_n_o); end
    bus.pll_locked = 1'b1;
    step(3);
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    step(3);
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL swhold_e7 got=%b exp=000", bus.rst_n_o); end
    step(1);
    checks++; if (bus.rst_n_o !== 3'b001) begin errors++; $display("FAIL swhold_e8 got=%b exp=001", bus.rst_n_o); end
    checks++; if (bus.rst_cause !== 4'b0100) begin errors++; $display("FAIL swhold_cause got=%b exp=0100", bus.rst_cause); end
    step(6);
    checks++; if (bus.rst_n_o !== 3'b111) begin errors++; $display("FAIL swhold_run got=%b exp=111", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL swhold_ready got=%b exp=1", bus.ready); end
  endtask

  task automatic test_sw_and_lock();
    bus.pll_locked = 1'b0;
    step(2);
    checks++; if (bus.rst_n_o !== 3'b111) begin errors++; $display("FAIL both_e2 got=%b exp=111", bus.rst_n_o); end
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL both_e3 got=%b exp=000", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL both_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.rst_cause !== 4'b1100) begin errors++; $display("FAIL both_cause got=%b exp=1100", bus.rst_cause); end
  endtask

  task automatic test_async_reset();
    bus.pll_locked = 1'b1;
    step(7);
    checks++; if (bus.rst_n_o !== 3'b001) begin errors++; $display("FAIL async_pre got=%b exp=001", bus.rst_n_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL async_rst_n got=%b exp=000", bus.rst_n_o); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL async_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.rst_cause !== 4'b0001) begin errors++; $display("FAIL async_cause got=%b exp=0001", bus.rst_cause); end
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_por_release();
    test_button_press();
    test_button_glitch();
    test_lock_loss();
    test_sw_in_hold();
    test_sw_and_lock();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Multi-domain reset generator that replaces the single-output reset synchroniser in the board top level.
- Combines three reset causes: MMCM lock loss, a debounced reset button, and a software reset request.
- Deasserts NUM_DOMAINS active-low resets in a fixed order: domain 0 first (e.g. interconnect), then peripherals, then core.
- Records the cause of the most recent reset for firmware to read.

Parameters:
- NUM_DOMAINS, 3: number of sequenced reset outputs (1..8).
- SYNC_STAGES, 2: flop stages on the asynchronous inputs pll_locked and btn (>=2).
- DEBOUNCE_CYCLES, 10000: consecutive stable cycles before the debounced button changes (1 ms at 10 MHz).
- MIN_HOLD, 16: consecutive "ok" cycles required in HOLD before release begins (>=1).
- STAGE_DELAY, 16: cycles between successive domain releases (>=1).

Ports:
- clk, input, 1: sequencer clock (core_clk).
- rst, input, 1: reset, asynchronous, active-high (power-on / global).
- pll_locked, input, 1: MMCM LOCKED; asynchronous, synchronised internally.
- btn, input, 1: raw reset button; asynchronous, active-high.
- sw_rst_req, input, 1: one-cycle software reset pulse, synchronous to clk.
- rst_n_o, output, NUM_DOMAINS: per-domain active-low resets.
- ready, output, 1: high when all domains are released.
- rst_cause, output, 4: cause of the last reset. Bit 0 = POR, bit 1 = button, bit 2 = lock loss, bit 3 = software.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=HOLD, rst_n_o=0, ready=0, rst_cause=4'b0001.
  - Sync flops, debounce state, hold_cnt and stage_cnt all clear to 0.
- Input conditioning:
  - pll_locked passes through SYNC_STAGES flops to give locked_s.
  - btn passes through SYNC_STAGES flops and then the debouncer to give btn_db.
  - btn_db toggles only after DEBOUNCE_CYCLES consecutive cycles in which the synchronised value differs from btn_db. Any agreeing cycle clears the debounce counter.
- Derived signals:
  - cause_vec = {sw_rst_req, ~locked_s, btn_db, 1'b0}.
  - ok = locked_s & ~btn_db & ~sw_rst_req.
- FSM states are HOLD, RELEASE and RUN.
- HOLD:
  - rst_n_o stays all 0.
  - If !ok: hold_cnt=0.
  - Else if hold_cnt==MIN_HOLD-1: go to RELEASE, set rst_n_o[0]=1, stage_cnt=0.
  - Else: hold_cnt+1.
- RELEASE:
  - stage_cnt increments each cycle.
  - When stage_cnt==STAGE_DELAY-1: release the next domain (rst_n_o[k]=1) and clear stage_cnt.
  - Releasing the last domain enters RUN with ready=1 on that same edge.
  - If NUM_DOMAINS==1, HOLD goes directly to RUN.
- Any cause (cause_vec!=0) while in RELEASE or RUN, on the next edge:
  - state=HOLD, rst_n_o=0 (all domains together), ready=0, hold_cnt=0, stage_cnt=0.
  - rst_cause=cause_vec. Simultaneous causes set multiple bits.
  - Causes while already in HOLD do not change rst_cause; they only restart hold_cnt.
- Every output is registered, with no combinational path from input to output.
- Nominal release latency after rst falls, with pll_locked already high and btn low:
  - rst_n_o[0] rises at edge SYNC_STAGES+MIN_HOLD.
  - rst_n_o[k] rises STAGE_DELAY edges after rst_n_o[k-1].
- Boundary rules:
  - Lock lost mid-RELEASE: already-released domains are re-asserted immediately.
  - Button held indefinitely: the block stays in HOLD.
  - Button glitch shorter than DEBOUNCE_CYCLES: no effect.
  - sw_rst_req during HOLD: restarts the hold count.
- Counters are sized $clog2(max+1). No wrap-around is reachable.

Decomposition:
- Package rst_pkg holds:
  - the state enum (HOLD, RELEASE, RUN);
  - localparams for the cause bit indices (CAUSE_POR=0, CAUSE_BTN=1, CAUSE_PLL=2, CAUSE_SW=3).
- Sub-module debounce (parameter CYCLES): synchronised input in, stable level out, same clk/rst.
- The existing sync module is reused for the SYNC_STAGES chains.

Test Plan (NUM_DOMAINS=3, SYNC_STAGES=2, MIN_HOLD=4, STAGE_DELAY=3, DEBOUNCE_CYCLES=5):
1. POR release: rst deasserts at edge 0, pll_locked=1 → rst_n_o = 001 at edge 6, 011 at edge 9, 111 at edge 12; ready=1 at edge 12; rst_cause=0001.
2. Button press in RUN, btn high for 20 cycles → rst_n_o=000 at edge 2+5+1 after the press; rst_cause=0010. Release after btn falls follows the scenario 1 timing measured from btn_db falling.
3. Button glitch of 4 cycles in RUN → rst_n_o stays 111, ready stays 1.
4. pll_locked drops while rst_n_o=011 → rst_n_o=000 on edge SYNC_STAGES+1 after the drop; rst_cause=0100; no release until lock returns plus MIN_HOLD cycles.
5. sw_rst_req pulse in the same cycle as lock loss, in RUN → rst_cause=1100; all domains asserted on the next edge.
6. rst asserted asynchronously mid-RELEASE → rst_n_o=000, ready=0, rst_cause=0001 immediately, without waiting for a clk edge.
